// File: rtl/sakura_x_ctrl_link.sv
// Control-FPGA endpoint of the 16-bit level-toggle link to the main FPGA.
// Optional ack timeout with sticky flag: define LINK_TIMEOUT_EN.
module sakura_x_ctrl_link #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic        device_rdy,
    output logic [15:0] c2m_din,
    output logic        c2m_en_lvl,
    input  logic        c2m_done_lvl,
    input  logic [15:0] m2c_dout,
    input  logic        m2c_en_lvl,
    output logic        m2c_done_lvl,
    output logic        tx_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_ACK
    } tx_state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    tx_state_t             state;
    logic [SW-1:0]         settle_cnt;
    logic [SYNC_STAGES-1:0] done_sq;
    logic [SYNC_STAGES-1:0] en_sq;
    logic [SYNC_STAGES-1:0] rdy_sq;
    logic                  done_sync;
    logic                  en_sync;
    logic                  rdy_sync;
    logic                  rx_capture;

    // Inbound level synchronisers, all clear to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_sq <= '0;
            en_sq   <= '0;
            rdy_sq  <= '0;
        end else begin
            done_sq <= {done_sq[SYNC_STAGES-2:0], c2m_done_lvl};
            en_sq   <= {en_sq[SYNC_STAGES-2:0], m2c_en_lvl};
            rdy_sq  <= {rdy_sq[SYNC_STAGES-2:0], device_rdy};
        end
    end

    assign done_sync = done_sq[SYNC_STAGES-1];
    assign en_sync   = en_sq[SYNC_STAGES-1];
    assign rdy_sync  = rdy_sq[SYNC_STAGES-1];

    assign tx_ready = (state == IDLE) && rdy_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            c2m_din    <= '0;
            c2m_en_lvl <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        c2m_din    <= tx_data;
                        settle_cnt <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        c2m_en_lvl <= ~c2m_en_lvl;
                        state      <= WAIT_ACK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // device_rdy is ignored here: a started word always completes.
                    if (done_sync == c2m_en_lvl) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINK_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt     <= '0;
            tx_timeout <= 1'b0;
        end else if (state != WAIT_ACK) begin
            to_cnt <= '0;
        end else begin
            if (to_cnt != 16'hFFFF) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (to_cnt == TO_LAST) begin
                tx_timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign tx_timeout     = 1'b0;
`endif

    // A full buffer withholds the ack, which stalls the main FPGA.
    assign rx_capture = (en_sync != m2c_done_lvl) && (!rx_valid || rx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            m2c_done_lvl <= 1'b0;
        end else if (rx_capture) begin
            rx_data      <= m2c_dout;
            rx_valid     <= 1'b1;
            m2c_done_lvl <= ~m2c_done_lvl;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sakura_x_ctrl_link.sv
// Directed bench for sakura_x_ctrl_link with a hand-driven main-FPGA model.
// Timeout expectations follow LINK_TIMEOUT_EN.
module tb_sakura_x_ctrl_link;

    logic        clk;
    logic        rst_n;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        device_rdy;
    logic [15:0] c2m_din;
    logic        c2m_en_lvl;
    logic        c2m_done_lvl;
    logic [15:0] m2c_dout;
    logic        m2c_en_lvl;
    logic        m2c_done_lvl;
    logic        tx_timeout;

    int n_checks;
    int n_fails;

`ifdef LINK_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    sakura_x_ctrl_link #(
        .SYNC_STAGES   (2),
        .SETTLE_CYCLES (2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .device_rdy  (device_rdy),
        .c2m_din     (c2m_din),
        .c2m_en_lvl  (c2m_en_lvl),
        .c2m_done_lvl(c2m_done_lvl),
        .m2c_dout    (m2c_dout),
        .m2c_en_lvl  (m2c_en_lvl),
        .m2c_done_lvl(m2c_done_lvl),
        .tx_timeout  (tx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        rst_n        = 1'b0;
        tx_data      = '0;
        tx_valid     = 1'b0;
        rx_ready     = 1'b0;
        device_rdy   = 1'b1;
        c2m_done_lvl = 1'b0;
        m2c_dout     = '0;
        m2c_en_lvl   = 1'b0;
        tick(3);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_c2m_en", c2m_en_lvl, 0);
        check("rst_m2c_done", m2c_done_lvl, 0);
        check("rst_c2m_din", c2m_din, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_timeout", tx_timeout, 0);
        rst_n = 1'b1;
        tick();
        check("rdy_edge1", tx_ready, 0);
        tick();
        check("rdy_edge2", tx_ready, 1);

        // TX A5C3, ack 10 cycles after the en toggle
        tx_data  = 16'hA5C3;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("tx1_din_T", c2m_din, 16'hA5C3);
        check("tx1_busy_T", tx_ready, 0);
        check("tx1_en_T", c2m_en_lvl, 0);
        tick();
        check("tx1_en_T1", c2m_en_lvl, 0);
        tick();
        check("tx1_en_T2", c2m_en_lvl, 1);
        tick(10);
        check("tx1_wait_rdy", tx_ready, 0);
        check("tx1_din_held", c2m_din, 16'hA5C3);
        c2m_done_lvl = 1'b1;
        tick(2);
        check("tx1_ack_e2", tx_ready, 0);
        tick();
        check("tx1_ack_e3", tx_ready, 1);

        // RX 1234, latency of three edges
        m2c_dout   = 16'h1234;
        m2c_en_lvl = 1'b1;
        tick(2);
        check("rx1_e2_valid", rx_valid, 0);
        check("rx1_e2_done", m2c_done_lvl, 0);
        tick();
        check("rx1_valid", rx_valid, 1);
        check("rx1_data", rx_data, 16'h1234);
        check("rx1_done", m2c_done_lvl, 1);

        // Second word while buffer is full
        m2c_dout   = 16'hBEEF;
        m2c_en_lvl = 1'b0;
        tick(5);
        check("rx2_bp_done", m2c_done_lvl, 1);
        check("rx2_bp_data", rx_data, 16'h1234);
        check("rx2_bp_valid", rx_valid, 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx2_data", rx_data, 16'hBEEF);
        check("rx2_done", m2c_done_lvl, 0);
        check("rx2_valid", rx_valid, 1);
        tick(2);
        check("rx2_hold", rx_data, 16'hBEEF);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx2_drain", rx_valid, 0);

        // Concurrent TX 0001 and RX FFFF
        tx_data    = 16'h0001;
        tx_valid   = 1'b1;
        m2c_dout   = 16'hFFFF;
        m2c_en_lvl = 1'b1;
        rx_ready   = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("cc_din_T", c2m_din, 16'h0001);
        tick(2);
        rx_ready = 1'b0;
        check("cc_en_T2", c2m_en_lvl, 0);
        check("cc_rx_valid", rx_valid, 1);
        check("cc_rx_data", rx_data, 16'hFFFF);
        check("cc_m2c_done", m2c_done_lvl, 1);
        c2m_done_lvl = 1'b0;
        tick(3);
        check("cc_tx_ready", tx_ready, 1);
        check("cc_din_keep", c2m_din, 16'h0001);
        check("cc_rx_keep", rx_data, 16'hFFFF);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("cc_drain", rx_valid, 0);

        // device_rdy drops mid-transfer: word still completes
        tx_data  = 16'h0F0F;
        tx_valid = 1'b1;
        tick();
        tx_valid   = 1'b0;
        device_rdy = 1'b0;
        tick(2);
        check("dr_en", c2m_en_lvl, 1);
        check("dr_din", c2m_din, 16'h0F0F);
        c2m_done_lvl = 1'b1;
        tick(4);
        check("dr_blocked", tx_ready, 0);
        device_rdy = 1'b1;
        tick();
        check("dr_rdy_e1", tx_ready, 0);
        tick();
        check("dr_rdy_e2", tx_ready, 1);

        // Ack withheld for 100 WAIT_ACK cycles
        tx_data  = 16'h5555;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick(2);
        check("to_en", c2m_en_lvl, 0);
        tick(99);
        check("to_before", tx_timeout, 0);
        tick();
        check("to_at_limit", tx_timeout, TO_EXP);
        check("to_no_ready", tx_ready, 0);
        tick(20);
        check("to_sticky", tx_timeout, TO_EXP);
        c2m_done_lvl = 1'b0;
        tick(3);
        check("to_late_ack", tx_ready, 1);
        check("to_after_ack", tx_timeout, TO_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
